conv_window_buffer: RTL and testbench

Streaming, parametrised successor to the combinational sliding-window input mapper. It accepts feature-map rows one per handshake, holds the last K rows in a row buffer, and forms N_C horizontally adjacent K×K windows with configurable stride. It emits one registered, element-major macro vector per window row-position (element k of all N_C windows contiguous) through a valid/ready handshake. It sits between the row fetch unit and the MAC macro input port.

---
 rtl/conv_window_buffer_pkg.sv | 16 +
 rtl/conv_window_buffer_window_row_buf.sv | 34 +++
 rtl/conv_window_buffer.sv | 90 +++++++++
 tb/tb_conv_window_buffer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_buffer_pkg.sv
// Shared configuration for the streaming convolution window buffer.
// Holds the default geometry constants and the derived row-width helper.
package conv_window_buffer_pkg;

  localparam int unsigned CFG_FXP        = 8;
  localparam int unsigned CFG_MAC_CN_HGT = 9;
  localparam int unsigned CFG_N_C        = 32;

  // Pixels per input row needed to cover n_c windows of width k at the given stride.
  function automatic int unsigned calc_row_w(input int unsigned n_c,
                                             input int unsigned k,
                                             input int unsigned stride);
    return (n_c - 1) * stride + k;
  endfunction

endpackage

// File: rtl/conv_window_buffer_window_row_buf.sv
// K-row shift register: an accepted row enters as the newest row (r=K-1),
// row 0 is the oldest. Contents are exposed flat, row r at [r*ROW_W*FXP +: ROW_W*FXP].
module window_row_buf #(
  parameter int unsigned FXP   = 8,
  parameter int unsigned K     = 9,
  parameter int unsigned ROW_W = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [ROW_W*FXP-1:0]     row_in,
  output logic [K*ROW_W*FXP-1:0]   rows_flat
);

  logic [ROW_W*FXP-1:0] rows [K];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < K; r++) begin
        rows[r] <= '0;
      end
    end else if (load) begin
      for (int unsigned r = 0; r + 1 < K; r++) begin
        rows[r] <= rows[r+1];
      end
      rows[K-1] <= row_in;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_flat
    assign rows_flat[r*ROW_W*FXP +: ROW_W*FXP] = rows[r];
  end

endmodule

// File: rtl/conv_window_buffer.sv
// Streaming sliding-window buffer: buffers K rows, captures N_C adjacent KxK windows
// into an element-major registered vector, and hands it off over valid/ready.
module conv_window_buffer
  import conv_window_buffer_pkg::*;
#(
  parameter int unsigned FXP    = CFG_FXP,
  parameter int unsigned K      = CFG_MAC_CN_HGT,
  parameter int unsigned N_C    = CFG_N_C,
  parameter int unsigned STRIDE = 1,
  localparam int unsigned ROW_W = calc_row_w(N_C, K, STRIDE),
  localparam int unsigned N_R   = K * K
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [ROW_W*FXP-1:0]     ROW_IN,
  input  logic                     ROW_SOF,
  input  logic                     ROW_VALID,
  output logic                     ROW_READY,
  output logic [N_C*N_R*FXP-1:0]   MACRO_IN,
  output logic                     OUT_FIRST,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY
);

  localparam int unsigned NW = $clog2(K + 1);

  logic [NW-1:0]              need_cnt;
  logic                       first_pending;
  logic                       accept;
  logic                       capture;
  logic [K*ROW_W*FXP-1:0]     rows_flat;
  logic [N_C*N_R*FXP-1:0]     win_vec;

  // ROW_READY depends only on need_cnt, so the buffer cannot shift under a pending window.
  assign ROW_READY = (need_cnt != '0);
  assign accept    = ROW_VALID && ROW_READY;
  assign capture   = (need_cnt == '0) && (!OUT_VALID || OUT_READY);

  window_row_buf #(
    .FXP   (FXP),
    .K     (K),
    .ROW_W (ROW_W)
  ) u_row_buf (
    .clk       (CLK),
    .rst       (RST),
    .load      (accept),
    .row_in    (ROW_IN),
    .rows_flat (rows_flat)
  );

  // Element k of window i comes from row k/K, pixel i*STRIDE + k%K.
  for (genvar k = 0; k < N_R; k++) begin : g_k
    for (genvar i = 0; i < N_C; i++) begin : g_i
      localparam int unsigned R   = k / K;
      localparam int unsigned C   = k % K;
      localparam int unsigned SRC = R * ROW_W + i * STRIDE + C;
      assign win_vec[(k*N_C+i)*FXP +: FXP] = rows_flat[SRC*FXP +: FXP];
    end
  end

  // capture and accept are mutually exclusive: capture needs need_cnt==0, accept needs it nonzero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      need_cnt      <= NW'(K);
      first_pending <= 1'b1;
      OUT_VALID     <= 1'b0;
      OUT_FIRST     <= 1'b0;
      MACRO_IN      <= '0;
    end else if (capture) begin
      MACRO_IN      <= win_vec;
      OUT_VALID     <= 1'b1;
      OUT_FIRST     <= first_pending;
      first_pending <= 1'b0;
      need_cnt      <= NW'(STRIDE);
    end else begin
      if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
      if (accept) begin
        if (ROW_SOF) begin
          need_cnt      <= NW'(K - 1);
          first_pending <= 1'b1;
        end else begin
          need_cnt <= need_cnt - NW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer with K=3, N_C=4, FXP=8 at STRIDE 1 and 2.
// Pixel value is base + 16*row + col.
module tb_conv_window_buffer;

  localparam int FXP = 8;
  localparam int K   = 3;
  localparam int N_C = 4;
  localparam int VW  = N_C * K * K * FXP;
  localparam int RW1 = 6 * FXP;
  localparam int RW2 = 9 * FXP;

  typedef struct {
    int         k;
    int         i;
    logic [7:0] exp;
  } elem_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           r1_rst, r1_sof, r1_valid, r1_ready, r1_first, r1_ovalid, r1_oready;
  logic [RW1-1:0] r1_row;
  logic [VW-1:0]  r1_macro;
  logic           r2_rst, r2_sof, r2_valid, r2_ready, r2_first, r2_ovalid, r2_oready;
  logic [RW2-1:0] r2_row;
  logic [VW-1:0]  r2_macro;

  int checks = 0;
  int errors = 0;

  conv_window_buffer #(.FXP(FXP), .K(K), .N_C(N_C), .STRIDE(1)) dut1 (
    .CLK(clk), .RST(r1_rst), .ROW_IN(r1_row), .ROW_SOF(r1_sof), .ROW_VALID(r1_valid),
    .ROW_READY(r1_ready), .MACRO_IN(r1_macro), .OUT_FIRST(r1_first),
    .OUT_VALID(r1_ovalid), .OUT_READY(r1_oready)
  );

  conv_window_buffer #(.FXP(FXP), .K(K), .N_C(N_C), .STRIDE(2)) dut2 (
    .CLK(clk), .RST(r2_rst), .ROW_IN(r2_row), .ROW_SOF(r2_sof), .ROW_VALID(r2_valid),
    .ROW_READY(r2_ready), .MACRO_IN(r2_macro), .OUT_FIRST(r2_first),
    .OUT_VALID(r2_ovalid), .OUT_READY(r2_oready)
  );

  // Record every STRIDE=2 handshake.
  logic [VW-1:0] cap2       [8];
  logic          cap2_first [8];
  int            cap2_n = 0;
  always @(posedge clk) begin
    if (!r2_rst && r2_ovalid && r2_oready && cap2_n < 8) begin
      cap2[cap2_n]       <= r2_macro;
      cap2_first[cap2_n] <= r2_first;
      cap2_n             <= cap2_n + 1;
    end
  end

  task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [RW2-1:0] mk_row(input int base, input int row);
    logic [RW2-1:0] v;
    v = '0;
    for (int c = 0; c < 9; c++) v[c*8 +: 8] = 8'(base + 16*row + c);
    return v;
  endfunction

  function automatic logic [VW-1:0] model_vec(input int base, input int top, input int stride);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < K*K; k++)
      for (int i = 0; i < N_C; i++)
        v[(k*N_C+i)*FXP +: FXP] = 8'(base + 16*(top + k/K) + i*stride + k%K);
    return v;
  endfunction

  task automatic send1(input logic [RW2-1:0] r, input logic sof);
    bit ok;
    ok = 1'b0;
    r1_row = r[RW1-1:0]; r1_sof = sof; r1_valid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (r1_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    r1_valid = 1'b0; r1_sof = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send1_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  task automatic send2(input logic [RW2-1:0] r, input logic sof);
    bit ok;
    ok = 1'b0;
    r2_row = r; r2_sof = sof; r2_valid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (r2_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    r2_valid = 1'b0; r2_sof = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send2_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    elem_t       tbl [8];
    logic [7:0]  e;
    logic [VW-1:0] tmp;
    int          low_cnt;

    tbl[0] = '{4, 2, 8'h13};
    tbl[1] = '{8, 3, 8'h25};
    tbl[2] = '{0, 0, 8'h00};
    tbl[3] = '{1, 1, 8'h02};
    tbl[4] = '{5, 0, 8'h12};
    tbl[5] = '{6, 3, 8'h23};
    tbl[6] = '{3, 1, 8'h11};
    tbl[7] = '{7, 2, 8'h23};

    r1_rst = 1'b1; r1_sof = 1'b0; r1_valid = 1'b0; r1_oready = 1'b0; r1_row = '0;
    r2_rst = 1'b1; r2_sof = 1'b0; r2_valid = 1'b0; r2_oready = 1'b0; r2_row = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    r1_rst = 1'b0; r2_rst = 1'b0;
    chk_bit("rst_out_valid", r1_ovalid, 1'b0);
    chk_vec("rst_macro", r1_macro, '0);
    chk_bit("rst_row_ready", r1_ready, 1'b1);
    chk_bit("rst_out_first", r1_first, 1'b0);
    chk_bit("rst_out_valid_s2", r2_ovalid, 1'b0);
    chk_bit("rst_row_ready_s2", r2_ready, 1'b1);

    // STRIDE=2 frame of 7 rows
    r2_oready = 1'b1;
    send2(mk_row(0, 0), 1'b1);
    for (int r = 1; r < 7; r++) send2(mk_row(0, r), 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk_byte("s2_vector_count", 8'(cap2_n), 8'd3);
    chk_vec("s2_vec0", cap2[0], model_vec(0, 0, 2));
    chk_vec("s2_vec1", cap2[1], model_vec(0, 2, 2));
    chk_vec("s2_vec2", cap2[2], model_vec(0, 4, 2));
    tmp = cap2[1];
    e = tmp[(0*N_C+1)*FXP +: FXP];
    chk_byte("s2_vec1_k0_i1", e, 8'h22);
    chk_bit("s2_first0", cap2_first[0], 1'b1);
    chk_bit("s2_first1", cap2_first[1], 1'b0);
    chk_bit("s2_first2", cap2_first[2], 1'b0);
    chk_bit("s2_idle_valid", r2_ovalid, 1'b0);

    // First window, STRIDE=1
    r1_oready = 1'b1;
    send1(mk_row(0, 0), 1'b1);
    send1(mk_row(0, 1), 1'b0);
    send1(mk_row(0, 2), 1'b0);
    chk_bit("lat_cycle1_valid", r1_ovalid, 1'b0);
    @(posedge clk); #1;
    chk_bit("win0_valid", r1_ovalid, 1'b1);
    chk_bit("win0_first", r1_first, 1'b1);
    for (int n = 0; n < 8; n++) begin
      e = r1_macro[(tbl[n].k*N_C + tbl[n].i)*FXP +: FXP];
      chk_byte($sformatf("win0_k%0d_i%0d", tbl[n].k, tbl[n].i), e, tbl[n].exp);
    end
    chk_vec("win0_full", r1_macro, model_vec(0, 0, 1));

    // Backpressure
    r1_oready = 1'b0;
    send1(mk_row(0, 3), 1'b0);
    r1_row = mk_row(0, 4)[RW1-1:0];
    r1_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      chk_bit("bp_row_ready", r1_ready, 1'b0);
      chk_bit("bp_valid", r1_ovalid, 1'b1);
      chk_bit("bp_first", r1_first, 1'b1);
      chk_vec("bp_macro_hold", r1_macro, model_vec(0, 0, 1));
    end
    r1_oready = 1'b1;
    @(posedge clk); #1;
    chk_bit("bp_next_valid", r1_ovalid, 1'b1);
    chk_bit("bp_next_first", r1_first, 1'b0);
    e = r1_macro[7:0];
    chk_byte("bp_next_k0_i0", e, 8'h10);
    chk_vec("bp_next_full", r1_macro, model_vec(0, 1, 1));
    chk_bit("bp_next_row_ready", r1_ready, 1'b1);
    @(posedge clk); #1;
    r1_valid = 1'b0;
    chk_bit("b2b_gap_valid", r1_ovalid, 1'b0);
    @(posedge clk); #1;
    chk_bit("b2b_valid", r1_ovalid, 1'b1);
    chk_vec("b2b_full", r1_macro, model_vec(0, 2, 1));
    chk_bit("b2b_first", r1_first, 1'b0);
    @(posedge clk); #1;
    chk_bit("b2b_drain_valid", r1_ovalid, 1'b0);

    // SOF mid-frame
    send1(mk_row(0, 0), 1'b1);
    chk_bit("sof_a_valid", r1_ovalid, 1'b0);
    send1(mk_row(0, 1), 1'b0);
    chk_bit("sof_b_valid", r1_ovalid, 1'b0);
    send1(mk_row(128, 0), 1'b1);
    chk_bit("sof_c_valid", r1_ovalid, 1'b0);
    send1(mk_row(128, 1), 1'b0);
    @(posedge clk); #1;
    chk_bit("sof_d_valid", r1_ovalid, 1'b0);
    send1(mk_row(128, 2), 1'b0);
    @(posedge clk); #1;
    r1_oready = 1'b0;
    chk_bit("sof_out_valid", r1_ovalid, 1'b1);
    chk_bit("sof_out_first", r1_first, 1'b1);
    chk_vec("sof_out_full", r1_macro, model_vec(128, 0, 1));
    low_cnt = 0;
    for (int b = 0; b < VW/8; b++) if (r1_macro[b*8 +: 8] < 8'h80) low_cnt++;
    chk_byte("sof_no_old_pixels", 8'(low_cnt), 8'd0);

    // Reset while an output is pending and stalled
    @(posedge clk); #1;
    chk_bit("pre_rst_valid", r1_ovalid, 1'b1);
    r1_rst = 1'b1;
    r1_row = mk_row(96, 0)[RW1-1:0];
    r1_valid = 1'b1;
    @(posedge clk); #1;
    r1_rst = 1'b0;
    r1_valid = 1'b0;
    chk_bit("mid_rst_valid", r1_ovalid, 1'b0);
    chk_bit("mid_rst_first", r1_first, 1'b0);
    chk_vec("mid_rst_macro", r1_macro, '0);
    chk_bit("mid_rst_ready", r1_ready, 1'b1);
    r1_oready = 1'b1;
    send1(mk_row(64, 0), 1'b0);
    send1(mk_row(64, 1), 1'b0);
    @(posedge clk); #1;
    chk_bit("post_rst_two_rows_valid", r1_ovalid, 1'b0);
    send1(mk_row(64, 2), 1'b0);
    @(posedge clk); #1;
    chk_bit("post_rst_valid", r1_ovalid, 1'b1);
    chk_bit("post_rst_first", r1_first, 1'b1);
    chk_vec("post_rst_full", r1_macro, model_vec(64, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
